// File: rtl/text_line_renderer_pkg.sv
// Shared definitions for the text line renderer: character codes of the
// font ROM, glyph geometry and the sequencer state encoding.
package text_line_renderer_pkg;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 8;

   localparam logic [4:0] CH_0     = 5'd0;
   localparam logic [4:0] CH_1     = 5'd1;
   localparam logic [4:0] CH_2     = 5'd2;
   localparam logic [4:0] CH_3     = 5'd3;
   localparam logic [4:0] CH_4     = 5'd4;
   localparam logic [4:0] CH_5     = 5'd5;
   localparam logic [4:0] CH_6     = 5'd6;
   localparam logic [4:0] CH_7     = 5'd7;
   localparam logic [4:0] CH_8     = 5'd8;
   localparam logic [4:0] CH_9     = 5'd9;
   localparam logic [4:0] CH_COLON = 5'd10;
   localparam logic [4:0] CH_SLASH = 5'd11;
   localparam logic [4:0] CH_DASH  = 5'd12;
   localparam logic [4:0] CH_SPACE = 5'd13;
   localparam logic [4:0] CH_C     = 5'd14;
   localparam logic [4:0] CH_EQ    = 5'd19;
   localparam logic [4:0] CH_L     = 5'd20;
   localparam logic [4:0] CH_E     = 5'd21;
   localparam logic [4:0] CH_D     = 5'd22;
   localparam logic [4:0] CH_O     = 5'd23;
   localparam logic [4:0] CH_X     = 5'd24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/text_line_renderer_text_buffer.sv
// Line text store: NUM_CHARS x 5-bit register file, one write port,
// one combinational read port, every entry reset to the blank glyph code.
module text_line_renderer_text_buffer
   import text_line_renderer_pkg::*;
#(
   parameter int NUM_CHARS  = 16,
   parameter int BLANK_CODE = 13,
   localparam int AW = $clog2(NUM_CHARS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [5:0]    wr_addr,
   input  logic [4:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [4:0]    rd_data
);

   logic [4:0] mem [NUM_CHARS];

   // NOTE: this is a small register file, not a RAM macro, so every entry is
   // reset; a real SRAM could not be cleared this way and would need a sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHARS; i++) mem[i] <= 5'(BLANK_CODE);
      end else if (wr_en && ({1'b0, wr_addr} < 7'(NUM_CHARS))) begin
         mem[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   // Read is combinational so a write lands only after the fetch that sees it.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/text_line_renderer.sv
// Walks glyph rows and characters of the text buffer through the external
// font ROM and serialises each bitmap byte MSB first on a valid/ready stream.
module text_line_renderer
   import text_line_renderer_pkg::*;
#(
   parameter int NUM_CHARS  = 16,
   parameter int BLANK_CODE = 13,
   localparam int XW = $clog2(NUM_CHARS * 8)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [5:0]    wr_addr,
   input  logic [4:0]    wr_data,
   input  logic          start,
   input  logic          abort,
   output logic [4:0]    rom_char_code,
   output logic [2:0]    rom_row,
   input  logic [7:0]    rom_bitmap,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic          pix_data,
   output logic [XW-1:0] pix_x,
   output logic [2:0]    pix_y,
   output logic          line_end,
   output logic          busy,
   output logic          frame_done
);

   localparam int CW = $clog2(NUM_CHARS);
   localparam int BW = $clog2(GLYPH_W);
   localparam logic [CW-1:0] LAST_CHAR = CW'(NUM_CHARS - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(GLYPH_W - 1);
   localparam logic [2:0]    LAST_ROW  = 3'(GLYPH_H - 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   char_idx, char_nxt;
   logic [2:0]      row_idx, row_nxt;
   logic [BW-1:0]   bit_idx, bit_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic [4:0]      rd_data;

   text_line_renderer_text_buffer #(
      .NUM_CHARS  (NUM_CHARS),
      .BLANK_CODE (BLANK_CODE)
   ) u_text_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (char_idx),
      .rd_data (rd_data)
   );

   // Indices only move on fetch/accept, so the ROM address holds between fetches.
   assign rom_char_code = rd_data;
   assign rom_row       = row_idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         char_idx <= '0;
         row_idx  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_nxt;
         char_idx <= char_nxt;
         row_idx  <= row_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
      end
   end

   // NOTE: every signal written here gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      char_nxt  = char_idx;
      row_nxt   = row_idx;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               char_nxt  = '0;
               row_nxt   = '0;
            end
         end
         FETCH: begin
            shreg_nxt = rom_bitmap;
            bit_nxt   = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (pix_ready) begin
               shreg_nxt = {shreg[6:0], 1'b0};
               bit_nxt   = bit_idx + 1'b1;
               if (bit_idx == LAST_BIT) begin
                  if (char_idx != LAST_CHAR) begin
                     char_nxt  = char_idx + 1'b1;
                     state_nxt = FETCH;
                  end else if (row_idx != LAST_ROW) begin
                     char_nxt  = '0;
                     row_nxt   = row_idx + 1'b1;
                     state_nxt = FETCH;
                  end else begin
                     state_nxt = DONE;
                  end
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Abort overrides any transition, including one caused by an accept.
      if (abort && (state != IDLE)) state_nxt = IDLE;
   end

   always_comb begin
      pix_valid  = (state == SHIFT);
      pix_data   = (state == SHIFT) && shreg[7];
      pix_x      = (state == SHIFT) ? {char_idx, bit_idx} : '0;
      pix_y      = (state == SHIFT) ? row_idx : '0;
      line_end   = (state == SHIFT) && (char_idx == LAST_CHAR) && (bit_idx == LAST_BIT);
      busy       = (state != IDLE);
      frame_done = (state == DONE);
   end

endmodule

// File: tb/tb_text_line_renderer.sv
// Self-checking bench for text_line_renderer: a bench-owned font ROM and a
// per-pixel reference model derived from buffer contents and frame geometry.
module tb_text_line_renderer;

   localparam int N  = 16;
   localparam int XW = 7;
   localparam int PIX_PER_FRAME = N * 8 * 8;

   logic          clk = 1'b0;
   logic          rst, wr_en, start, abort, pix_ready;
   logic [5:0]    wr_addr;
   logic [4:0]    wr_data;
   logic [4:0]    rom_char_code;
   logic [2:0]    rom_row;
   logic [7:0]    rom_bitmap;
   logic          pix_valid, pix_data, line_end, busy, frame_done;
   logic [XW-1:0] pix_x;
   logic [2:0]    pix_y;

   logic          s_wr_en, s_start, s_abort, s_ready;
   logic [5:0]    s_wr_addr;
   logic [4:0]    s_wr_data;
   logic [4:0]    s_rom_char_code;
   logic [2:0]    s_rom_row;
   logic [7:0]    s_rom_bitmap;
   logic          s_pix_valid, s_pix_data, s_line_end, s_busy, s_frame_done;
   logic [3:0]    s_pix_x;
   logic [2:0]    s_pix_y;

   logic [4:0]    ref_buf [N];
   int            n_pass = 0;
   int            n_total = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   // Bench font: fixed rows for glyphs the plan names, a hash elsewhere.
   function automatic logic [7:0] font(input logic [4:0] code, input logic [2:0] row);
      if (code > 5'd24 || code == 5'd13) return 8'h00;
      if (code == 5'd0  && row == 3'd0) return 8'h3C;
      if (code == 5'd1  && row == 3'd0) return 8'h18;
      if (code == 5'd24 && row == 3'd2) return 8'h3C;
      return 8'(int'(code) * 29 + int'(row) * 83 + 17);
   endfunction

   assign rom_bitmap   = font(rom_char_code, rom_row);
   assign s_rom_bitmap = font(s_rom_char_code, s_rom_row);

   text_line_renderer #(.NUM_CHARS(N), .BLANK_CODE(13)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .abort(abort), .rom_char_code(rom_char_code), .rom_row(rom_row),
      .rom_bitmap(rom_bitmap), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .line_end(line_end),
      .busy(busy), .frame_done(frame_done)
   );

   text_line_renderer #(.NUM_CHARS(2), .BLANK_CODE(13)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .start(s_start), .abort(s_abort), .rom_char_code(s_rom_char_code), .rom_row(s_rom_row),
      .rom_bitmap(s_rom_bitmap), .pix_valid(s_pix_valid), .pix_ready(s_ready),
      .pix_data(s_pix_data), .pix_x(s_pix_x), .pix_y(s_pix_y), .line_end(s_line_end),
      .busy(s_busy), .frame_done(s_frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pix_obs();
      return 32'({pix_data, line_end, pix_y, pix_x});
   endfunction

   function automatic logic [31:0] pix_exp(input int idx, input bit wtest);
      int         y, x, c, b;
      logic [4:0] code;
      logic [7:0] bm;
      y = idx / (N * 8);
      x = idx % (N * 8);
      c = x / 8;
      b = x % 8;
      code = ref_buf[c];
      if (wtest && c == 9  && y >= 2) code = 5'd24;
      if (wtest && c == 10 && y >= 3) code = 5'd21;
      bm = font(code, 3'(y));
      return 32'({bm[7-b], (x == N * 8 - 1), 3'(y), 7'(x)});
   endfunction

   task automatic buf_write(input int a, input int d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 6'(a); wr_data = 5'(d);
      @(negedge clk);
      wr_en = 1'b0;
      if (a < N) ref_buf[a] = 5'(d);
   endtask

   // One frame; cycle 1 is the cycle in which start is high.
   task automatic run_frame(input string tag, input bit rand_ready, input int abort_at,
                            input bit wtest, input bit spam);
      int          idx, first_k, done_k, cnt;
      bit          stalled, aborted;
      logic [31:0] held;
      idx = 0; first_k = 0; done_k = 0; stalled = 0; aborted = 0; held = '0;
      @(negedge clk);
      start = 1'b1; pix_ready = 1'b1;
      for (int k = 2; k <= 6000; k++) begin
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0; abort = 1'b0;
         if (spam && k == 500) start = 1'b1;
         if (wtest && k == 2 + 9 * (2 * N + 9) - 1) begin
            wr_en = 1'b1; wr_addr = 6'd9; wr_data = 5'd24;
         end
         if (wtest && k == 2 + 9 * (2 * N + 10)) begin
            wr_en = 1'b1; wr_addr = 6'd10; wr_data = 5'd21;
         end
         if (stalled) chk({tag, "_stall_hold"}, {pix_valid, pix_obs()}, {1'b1, held});
         pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pix_valid && first_k == 0) first_k = k;
         if (pix_valid && idx == abort_at) begin
            pix_ready = 1'b0; abort = 1'b1; aborted = 1;
         end
         if (pix_valid && pix_ready) begin
            chk({tag, "_pixel"}, pix_obs(), pix_exp(idx, wtest));
            idx++;
         end
         stalled = pix_valid && !pix_ready && !abort;
         held = pix_obs();
         if (frame_done) begin
            done_k = k;
            if (spam) start = 1'b1;
            break;
         end
         if (aborted) break;
      end
      if (aborted) begin
         @(negedge clk);
         abort = 1'b0; pix_ready = 1'b1;
         chk({tag, "_abort_state"}, {pix_valid, busy, frame_done}, 3'b000);
         cnt = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done || busy) cnt++;
         end
         chk({tag, "_abort_quiet"}, cnt, 0);
      end else begin
         chk({tag, "_count"}, idx, PIX_PER_FRAME);
         chk({tag, "_first_valid"}, first_k, 3);
         if (rand_ready) chk({tag, "_done_seen"}, 32'(done_k != 0), 1);
         else            chk({tag, "_done_cycle"}, done_k, 1 + 9 * 8 * N + 1);
         @(negedge clk);
         start = 1'b0;
         chk({tag, "_idle_after"}, {busy, pix_valid, frame_done}, 3'b000);
      end
   endtask

   initial begin
      int          idx2, dk;
      logic [15:0] r0;
      logic [31:0] e2;
      logic [7:0]  bm;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
      s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
      s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
      for (int i = 0; i < N; i++) ref_buf[i] = 5'd13;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {pix_valid, pix_data, pix_x, pix_y, line_end, busy, frame_done}, '0);
      chk("reset_rom", {rom_char_code, rom_row}, {5'd13, 3'd0});
      rst = 1'b0;

      // abort while idle does nothing
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_idle", {busy, pix_valid}, 2'b00);

      run_frame("blank", 0, -1, 0, 0);

      // Two-character instance, row 0 pattern and line_end placement.
      @(negedge clk); s_wr_en = 1'b1; s_wr_addr = 6'd0; s_wr_data = 5'd0;
      @(negedge clk); s_wr_addr = 6'd1; s_wr_data = 5'd1;
      @(negedge clk); s_wr_en = 1'b0; s_start = 1'b1;
      idx2 = 0; dk = 0; r0 = '0;
      for (int k = 2; k <= 400; k++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_pix_valid) begin
            bm = font(5'((idx2 % 16) / 8), 3'(idx2 / 16));
            e2 = 32'({bm[7 - idx2 % 8], (idx2 % 16 == 15), 3'(idx2 / 16), 4'(idx2 % 16)});
            chk("n2_pixel", 32'({s_pix_data, s_line_end, s_pix_y, s_pix_x}), e2);
            if (s_pix_y == 3'd0) r0[15 - int'(s_pix_x)] = s_pix_data;
            idx2++;
         end
         if (s_frame_done) begin
            dk = k;
            break;
         end
      end
      chk("n2_row0", r0, 16'b0011110000011000);
      chk("n2_count", idx2, 128);
      chk("n2_done_cycle", dk, 1 + 9 * 8 * 2 + 1);

      // Random back-pressure over a buffer of '8'.
      for (int i = 0; i < N; i++) buf_write(i, 8);
      run_frame("stall", 1, -1, 0, 0);

      // Random text, abort at row 3 char 5 bit 2 while stalled, then restart.
      for (int i = 0; i < N; i++) buf_write(i, int'($urandom_range(0, 31)));
      buf_write(9, 3);
      buf_write(10, 4);
      run_frame("abort", 0, 3 * N * 8 + 5 * 8 + 2, 0, 0);
      run_frame("restart", 0, -1, 0, 0);

      // Writes racing the fetches of chars 9 and 10 in row 2.
      run_frame("wrace", 0, -1, 1, 0);
      ref_buf[9] = 5'd24;
      ref_buf[10] = 5'd21;

      // Out-of-range write, then start pulses while busy and during frame_done.
      buf_write(40, 0);
      run_frame("spam", 0, -1, 0, 1);

      // Reset mid-frame: outputs clear at once and the buffer reloads blanks.
      @(negedge clk); start = 1'b1; pix_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (300) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", {pix_valid, pix_data, pix_x, pix_y, line_end, busy, frame_done}, '0);
      chk("midrst_rom", {rom_char_code, rom_row}, {5'd13, 3'd0});
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < N; i++) ref_buf[i] = 5'd13;
      run_frame("postrst", 0, -1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/text_line_renderer.md
Name: text_line_renderer

Overview:
Sequences the combinational character font ROM to turn a line of character codes into a raster pixel stream for the LED/matrix display path. Holds a NUM_CHARS-entry text buffer written by the host logic. On start it walks glyph rows 0-7 and, within each row, characters 0 to NUM_CHARS-1. For each character it drives char_code/row to the font ROM, latches the 8-bit bitmap and emits 8 pixels, MSB first, over a valid/ready stream.

Parameters:
NUM_CHARS, 16, characters per line (2..64)
BLANK_CODE, 13, code loaded into every buffer entry at reset (space glyph)
XW, $clog2(NUM_CHARS*8), pixel x-coordinate width (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  text buffer write strobe
wr_addr  in  6  buffer index; writes with wr_addr >= NUM_CHARS are ignored
wr_data  in  5  character code to store
start  in  1  single-cycle frame render request; ignored unless idle
abort  in  1  terminate the render in progress
rom_char_code  out  5  to font ROM char_code
rom_row  out  3  to font ROM row
rom_bitmap  in  8  from font ROM bitmap (combinational, same cycle)
pix_valid  out  1  pixel stream valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  1  pixel value (1 = lit)
pix_x  out  XW  column = char_idx*8 + bit position (0 = leftmost)
pix_y  out  3  glyph row
line_end  out  1  qualifies the last pixel of a row (x = NUM_CHARS*8-1)
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last pixel of row 7 is accepted

Behaviour:
- Reset (async, rst=1): FSM to IDLE. All buffer entries = BLANK_CODE. Outputs pix_valid, pix_data, pix_x, pix_y, line_end, busy, frame_done = 0. rom_char_code = buffer[0], rom_row = 0. Reset asserted mid-frame discards the frame with no frame_done.
- Buffer writes are accepted in every state and take effect at the next clock edge. A FETCH in the same cycle as a write to the same index uses the old value.
- FSM states:
  - IDLE: start -> FETCH; char_idx = 0, row_idx = 0.
  - FETCH (1 cycle): rom_char_code = buffer[char_idx], rom_row = row_idx. The bitmap is latched into an 8-bit shift register, bit_idx = 0 -> SHIFT.
  - SHIFT: pix_valid = 1, pix_data = shreg[7], pix_x = char_idx*8 + bit_idx, pix_y = row_idx. On pix_valid & pix_ready the register shifts left and bit_idx increments.
    - On accept of bit_idx = 7: if char_idx < NUM_CHARS-1, char_idx++ -> FETCH.
    - Else if row_idx < 7: char_idx = 0, row_idx++ -> FETCH.
    - Else -> DONE.
  - DONE (1 cycle): frame_done = 1 -> IDLE.
- Latency: start sampled at edge N, so FETCH occupies cycle N+1 and pix_valid is first high in cycle N+2. Steady-state throughput with pix_ready tied to 1 is 8 pixels per 9 cycles. A full frame takes 1 + 9*8*NUM_CHARS + 1 cycles from start to frame_done inclusive (1154 for NUM_CHARS = 16).
- Handshake: while pix_valid & !pix_ready, pix_data, pix_x, pix_y and line_end hold stable and pix_valid stays high. pix_valid never drops without an accept except on abort or reset.
- start while busy is ignored. start in the same cycle as frame_done is also ignored, because the FSM is still in DONE that cycle.
- abort (any non-IDLE state) -> IDLE at the next edge. pix_valid drops that edge, no frame_done is issued, and the buffer is untouched. abort has priority over a coincident pixel accept; that accept still counts downstream. abort while IDLE has no effect.
- rom_row / rom_char_code are don't-care outside FETCH; they are held at their last value to reduce toggling.
- Char codes are passed to the ROM unchecked; codes > 24 render blank, per the ROM default.

Decomposition:
- Shared package: character code constants (CH_0..CH_9, CH_COLON=10, CH_SLASH=11, CH_DASH=12, CH_SPACE=13, CH_C=14 ... CH_EQ=19, CH_L=20, CH_E=21, CH_D=22, CH_O=23, CH_X=24), GLYPH_W=8, GLYPH_H=8, and the FSM state encoding (IDLE, FETCH, SHIFT, DONE).
- One sub-module is natural: text_buffer, a NUM_CHARS x 5 register file with async reset to BLANK_CODE, one write port and one combinational read port.
- The font ROM stays external and is instantiated alongside by the parent.

Test Plan:
- Reset, then start with pix_ready=1 and the default buffer -> 1024 pixels all 0; frame_done exactly 1154 cycles after the start edge; busy low afterwards.
- NUM_CHARS=2, write buf[0]=0 ('0') and buf[1]=1 ('1'), start -> row 0 pixels at x=0..15 read 0011110000011000; line_end high only at x=15; y goes 0..7 in order.
- pix_ready toggled randomly with buffer = 8 ('8') -> pixel sequence identical to the ready=1 run. Outputs stay stable during stalls, checked via assertion.
- abort in SHIFT at row 3, char 5, bit 2 with pix_ready=0 -> pix_valid=0 next cycle, busy=0, no frame_done. A following start restarts at x=0, y=0.
- During row 2, write buf[9]=24 ('X') one cycle before char 9's FETCH, and write buf[10]=21 ('E') in the same cycle as char 10's FETCH. Char 9 renders 'X' row 2 = 00111100; char 10 renders its old code.
- start pulsed while busy and again in the frame_done cycle -> both ignored. wr_addr=40 with NUM_CHARS=16 -> no buffer change. Assert rst mid-frame -> all outputs 0 immediately and buffer all 13.
